im_run_controller: RTL and testbench
====================================

// Module: im_run_controller
// PURPOSE
//  Owns the single instruction-memory port and sequences the run of the 16-bit pipelined processor.
//  While idle or halted, a host loader gets the memory port to write and read back the program.
//  While running, the IF stage gets the port; this block pulses the start input and holds the pipeline in reset otherwise.
//  On a stop from the pipeline it drains the pipeline for a fixed number of cycles, then halts.
// PARAMETERS
//  DATA_WIDTH    16  instruction word width
//  ADDR_WIDTH    8   instruction memory address width
//  DRAIN_CYCLES  4   cycles spent in DRAIN after stop_i before HALT (0 = go straight to HALT)
//  CNT_WIDTH     16  run-cycle counter width
// PORTS
//  clk            in   1           single clock, rising edge
//  rst_n          in   1           asynchronous, active-low reset
//  host_valid_i   in   1           host access request
//  host_ready_o   out  1           host access accepted this cycle (valid&&ready)
//  host_we_i      in   1           1=write, 0=read
//  host_addr_i    in   ADDR_WIDTH  host address
//  host_wdata_i   in   DATA_WIDTH  host write data
//  host_rdata_o   out  DATA_WIDTH  registered read data
//  host_rvalid_o  out  1           1-cycle pulse: host_rdata_o valid
//  host_go_i      in   1           start program from PC 0
//  host_abort_i   in   1           force halt from RUN/DRAIN
//  stop_i         in   1           stop flag from pipeline
//  fetch_addr_i   in   ADDR_WIDTH  IF fetch address
//  fetch_rd_i     in   1           IF read enable
//  im_addr_o      out  ADDR_WIDTH  IM address
//  im_rd_o        out  1           IM read enable
//  im_wr_o        out  1           IM write enable
//  im_wdata_o     out  DATA_WIDTH  IM write data
//  im_rdata_i     in   DATA_WIDTH  IM read data, combinational (same cycle as address)
//  start_o        out  1           1-cycle start pulse to IF stage
//  pipe_rst_o     out  1           active-high synchronous reset to pipeline
//  state_o        out  2           FSM state encoding
//  busy_o         out  1           state is RUN or DRAIN
//  done_o         out  1           state is HALT
//  cycle_cnt_o    out  CNT_WIDTH   cycles spent in RUN
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state = IDLE; start_o, host_rvalid_o, host_rdata_o and cycle_cnt_o = 0; drain counter = 0.
//   - pipe_rst_o = 1 immediately, including when reset hits mid-run.
//  FSM states: IDLE=0, RUN=1, DRAIN=2, HALT=3.
//   - IDLE/HALT -> RUN: on host_go_i.
//   - RUN -> DRAIN: on stop_i; if DRAIN_CYCLES=0, RUN -> HALT instead.
//   - DRAIN -> HALT: after DRAIN_CYCLES cycles counted in DRAIN.
//   - RUN/DRAIN -> HALT: on host_abort_i; abort has priority over stop_i.
//   - host_go_i is ignored in RUN/DRAIN; host_abort_i is ignored in IDLE/HALT.
//   - stop_i is sampled only in RUN, including the start_o cycle.
//  Outputs decoded from state flops (no combinational input path):
//   - pipe_rst_o = IDLE|HALT; busy_o = RUN|DRAIN; done_o = HALT; host_ready_o = IDLE|HALT.
//   - start_o is registered: high exactly on the first RUN cycle, the same cycle pipe_rst_o first drops.
//  Memory mux:
//   - RUN/DRAIN: im_addr_o=fetch_addr_i, im_rd_o=fetch_rd_i, im_wr_o=0.
//   - IDLE/HALT: im_addr_o=host_addr_i, im_wdata_o=host_wdata_i, im_wr_o=host_valid_i&host_we_i, im_rd_o=host_valid_i&~host_we_i.
//  Host read:
//   - Accepted in cycle N: im_rdata_i is captured at the end of N.
//   - host_rdata_o is valid and host_rvalid_o=1 in cycle N+1 only.
//   - host_rdata_o holds its value until the next read.
//  Host write: completes in the accepting cycle; no response.
//  Host access in the same cycle as host_go_i: the access completes; RUN starts next cycle.
//  Host requests during RUN/DRAIN stall (ready=0) until HALT. The host must hold valid and its address/data until ready.
//  cycle_cnt_o:
//   - Cleared to 0 on the go transition; +1 each RUN cycle; saturates at all-ones.
//   - Held in DRAIN/HALT/IDLE.
// TESTING
//  - Reset: rst_n=0 mid-RUN -> state_o=0, pipe_rst_o=1, start_o=0, cycle_cnt_o=0 with no clock edge.
//  - Load/readback: write 0x1234@0x05, 0xBEEF@0xFF in IDLE, then read 0x05 -> host_rvalid_o pulse next cycle with host_rdata_o=0x1234; im_wr_o seen exactly twice.
//  - Run: go -> start_o=1 and pipe_rst_o=0 on the next cycle; im_addr_o follows fetch_addr_i; stop_i after 10 RUN cycles -> 4 DRAIN cycles, then HALT with done_o=1, cycle_cnt_o=10.
//  - Host during RUN: host_valid_i=1 -> ready=0 and im_wr_o=0 until HALT, then accepted on the first HALT cycle.
//  - Collisions: abort and stop in the same RUN cycle -> HALT next cycle (no DRAIN); go during DRAIN ignored; DRAIN_CYCLES=0 -> RUN->HALT directly.
//  - Saturation: CNT_WIDTH=4, run 20 cycles -> cycle_cnt_o=15; a second go clears it to 0.

Source files
------------

// File: rtl/im_run_controller.sv
// rtl/im_run_controller.sv - instruction-memory port owner and run sequencer for the 16-bit pipeline
// Host loader owns the IM port while IDLE/HALT; the IF stage owns it while RUN/DRAIN.
module im_run_controller #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 8,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  host_valid_i,
    output logic                  host_ready_o,
    input  logic                  host_we_i,
    input  logic [ADDR_WIDTH-1:0] host_addr_i,
    input  logic [DATA_WIDTH-1:0] host_wdata_i,
    output logic [DATA_WIDTH-1:0] host_rdata_o,
    output logic                  host_rvalid_o,
    input  logic                  host_go_i,
    input  logic                  host_abort_i,
    input  logic                  stop_i,
    input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
    input  logic                  fetch_rd_i,
    output logic [ADDR_WIDTH-1:0] im_addr_o,
    output logic                  im_rd_o,
    output logic                  im_wr_o,
    output logic [DATA_WIDTH-1:0] im_wdata_o,
    input  logic [DATA_WIDTH-1:0] im_rdata_i,
    output logic                  start_o,
    output logic                  pipe_rst_o,
    output logic [1:0]            state_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  cycle_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = (DRAIN_CYCLES == 0) ? '0 : DCW'(DRAIN_CYCLES - 1);

    state_t                r_state;
    logic                  r_start;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DCW-1:0]        r_drain_cnt;

    logic w_host_side;
    logic w_host_rd;

    assign w_host_side = (r_state == S_IDLE) || (r_state == S_HALT);
    assign w_host_rd   = w_host_side & host_valid_i & ~host_we_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_start     <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_cnt       <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_start  <= 1'b0;
            r_rvalid <= w_host_rd;
            if (w_host_rd) begin
                r_rdata <= im_rdata_i;
            end
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (host_go_i) begin
                        r_state <= S_RUN;
                        r_start <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    if (!(&r_cnt)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    // abort wins over a simultaneous stop and skips the drain
                    if (host_abort_i) begin
                        r_state <= S_HALT;
                    end else if (stop_i) begin
                        r_drain_cnt <= '0;
                        if (DRAIN_CYCLES == 0) begin
                            r_state <= S_HALT;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (host_abort_i || (r_drain_cnt == DRAIN_LAST)) begin
                        r_state <= S_HALT;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        im_addr_o  = fetch_addr_i;
        im_rd_o    = fetch_rd_i;
        im_wr_o    = 1'b0;
        im_wdata_o = host_wdata_i;
        if (w_host_side) begin
            im_addr_o = host_addr_i;
            im_rd_o   = host_valid_i & ~host_we_i;
            im_wr_o   = host_valid_i & host_we_i;
        end
    end

    assign state_o       = r_state;
    assign pipe_rst_o    = w_host_side;
    assign host_ready_o  = w_host_side;
    assign busy_o        = ~w_host_side;
    assign done_o        = (r_state == S_HALT);
    assign start_o       = r_start;
    assign host_rvalid_o = r_rvalid;
    assign host_rdata_o  = r_rdata;
    assign cycle_cnt_o   = r_cnt;

endmodule

// File: tb/tb_im_run_controller.sv
// tb/tb_im_run_controller.sv - self-checking bench for im_run_controller
// Three instances share stimulus: default, DRAIN_CYCLES=0, CNT_WIDTH=4.
module tb_im_run_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        host_valid = 1'b0;
    logic        host_we = 1'b0;
    logic [7:0]  host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic        host_go = 1'b0;
    logic        host_abort = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  fetch_addr = '0;
    logic        fetch_rd = 1'b0;

    logic        ready  [3];
    logic [15:0] rdata  [3];
    logic        rvalid [3];
    logic [7:0]  im_addr [3];
    logic        im_rd  [3];
    logic        im_wr  [3];
    logic [15:0] im_wdata [3];
    logic [15:0] im_rdata [3];
    logic        start  [3];
    logic        prst   [3];
    logic [1:0]  st     [3];
    logic        busy   [3];
    logic        done   [3];
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic [3:0]  cnt2;

    logic [15:0] mem [3][256];
    int          wr_cnt [3];

    int checks = 0;
    int errors = 0;

    int          p_drain [3] = '{4, 0, 4};
    int          p_cmax  [3] = '{65535, 65535, 15};
    int          m_state [3];
    int          m_left  [3];
    int          m_cnt   [3];
    int          m_start [3];
    int          m_rvalid [3];
    logic [15:0] m_rdata [3];
    logic [15:0] m_mem [3][256];

    always #5 clk = ~clk;

    im_run_controller #(.DRAIN_CYCLES(4)) u_d4 (
        .clk(clk), .rst_n(rst_n),
        .host_valid_i(host_valid), .host_ready_o(ready[0]), .host_we_i(host_we),
        .host_addr_i(host_addr), .host_wdata_i(host_wdata),
        .host_rdata_o(rdata[0]), .host_rvalid_o(rvalid[0]),
        .host_go_i(host_go), .host_abort_i(host_abort), .stop_i(stop),
        .fetch_addr_i(fetch_addr), .fetch_rd_i(fetch_rd),
        .im_addr_o(im_addr[0]), .im_rd_o(im_rd[0]), .im_wr_o(im_wr[0]),
        .im_wdata_o(im_wdata[0]), .im_rdata_i(im_rdata[0]),
        .start_o(start[0]), .pipe_rst_o(prst[0]), .state_o(st[0]),
        .busy_o(busy[0]), .done_o(done[0]), .cycle_cnt_o(cnt0)
    );

    im_run_controller #(.DRAIN_CYCLES(0)) u_d0 (
        .clk(clk), .rst_n(rst_n),
        .host_valid_i(host_valid), .host_ready_o(ready[1]), .host_we_i(host_we),
        .host_addr_i(host_addr), .host_wdata_i(host_wdata),
        .host_rdata_o(rdata[1]), .host_rvalid_o(rvalid[1]),
        .host_go_i(host_go), .host_abort_i(host_abort), .stop_i(stop),
        .fetch_addr_i(fetch_addr), .fetch_rd_i(fetch_rd),
        .im_addr_o(im_addr[1]), .im_rd_o(im_rd[1]), .im_wr_o(im_wr[1]),
        .im_wdata_o(im_wdata[1]), .im_rdata_i(im_rdata[1]),
        .start_o(start[1]), .pipe_rst_o(prst[1]), .state_o(st[1]),
        .busy_o(busy[1]), .done_o(done[1]), .cycle_cnt_o(cnt1)
    );

    im_run_controller #(.CNT_WIDTH(4)) u_c4 (
        .clk(clk), .rst_n(rst_n),
        .host_valid_i(host_valid), .host_ready_o(ready[2]), .host_we_i(host_we),
        .host_addr_i(host_addr), .host_wdata_i(host_wdata),
        .host_rdata_o(rdata[2]), .host_rvalid_o(rvalid[2]),
        .host_go_i(host_go), .host_abort_i(host_abort), .stop_i(stop),
        .fetch_addr_i(fetch_addr), .fetch_rd_i(fetch_rd),
        .im_addr_o(im_addr[2]), .im_rd_o(im_rd[2]), .im_wr_o(im_wr[2]),
        .im_wdata_o(im_wdata[2]), .im_rdata_i(im_rdata[2]),
        .start_o(start[2]), .pipe_rst_o(prst[2]), .state_o(st[2]),
        .busy_o(busy[2]), .done_o(done[2]), .cycle_cnt_o(cnt2)
    );

    function automatic logic [15:0] pat(int k, int a);
        return 16'((a * 257) ^ (k * 4369) ^ 16'h5A5A);
    endfunction

    function automatic int cnt_of(int k);
        if (k == 0) return int'(cnt0);
        if (k == 1) return int'(cnt1);
        return int'(cnt2);
    endfunction

    assign im_rdata[0] = mem[0][im_addr[0]];
    assign im_rdata[1] = mem[1][im_addr[1]];
    assign im_rdata[2] = mem[2][im_addr[2]];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                wr_cnt[k] <= 0;
                for (int a = 0; a < 256; a++) mem[k][a] <= pat(k, a);
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (im_wr[k]) begin
                    mem[k][im_addr[k]] <= im_wdata[k];
                    wr_cnt[k] <= wr_cnt[k] + 1;
                end
            end
        end
    end

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_state[k] = 0; m_left[k] = 0; m_cnt[k] = 0;
            m_start[k] = 0; m_rvalid[k] = 0; m_rdata[k] = '0;
            for (int a = 0; a < 256; a++) m_mem[k][a] = pat(k, a);
        end
    endtask

    // Host side owns memory in IDLE(0)/HALT(3); drain length counted down from the parameter.
    task automatic model_update();
        for (int k = 0; k < 3; k++) begin
            bit hs;
            hs = (m_state[k] == 0) || (m_state[k] == 3);
            m_rvalid[k] = 0;
            m_start[k]  = 0;
            if (hs && host_valid) begin
                if (host_we) m_mem[k][host_addr] = host_wdata;
                else begin
                    m_rdata[k]  = m_mem[k][host_addr];
                    m_rvalid[k] = 1;
                end
            end
            if (hs) begin
                if (host_go) begin
                    m_state[k] = 1; m_start[k] = 1; m_cnt[k] = 0;
                end
            end else if (m_state[k] == 1) begin
                if (m_cnt[k] < p_cmax[k]) m_cnt[k] = m_cnt[k] + 1;
                if (host_abort) m_state[k] = 3;
                else if (stop) begin
                    if (p_drain[k] == 0) m_state[k] = 3;
                    else begin
                        m_state[k] = 2; m_left[k] = p_drain[k];
                    end
                end
            end else begin
                if (host_abort) m_state[k] = 3;
                else begin
                    m_left[k] = m_left[k] - 1;
                    if (m_left[k] == 0) m_state[k] = 3;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_update();
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (st[k] !== 2'd0) begin errors++; $display("FAIL reset_state k=%0d got=%0d exp=0", k, st[k]); end
            checks++; if (prst[k] !== 1'b1) begin errors++; $display("FAIL reset_pipe_rst k=%0d got=%b exp=1", k, prst[k]); end
            checks++; if (start[k] !== 1'b0) begin errors++; $display("FAIL reset_start k=%0d got=%b exp=0", k, start[k]); end
            checks++; if (cnt_of(k) !== 0) begin errors++; $display("FAIL reset_cnt k=%0d got=%0d exp=0", k, cnt_of(k)); end
            checks++; if (rvalid[k] !== 1'b0 || rdata[k] !== 16'h0) begin errors++; $display("FAIL reset_rd k=%0d got=%b/%h exp=0/0000", k, rvalid[k], rdata[k]); end
            checks++; if (ready[k] !== 1'b1 || busy[k] !== 1'b0 || done[k] !== 1'b0) begin errors++; $display("FAIL reset_flags k=%0d got=%b%b%b exp=100", k, ready[k], busy[k], done[k]); end
        end
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_load();
        int wc0;
        wc0 = wr_cnt[0];
        host_valid = 1'b1; host_we = 1'b1; host_addr = 8'h05; host_wdata = 16'h1234;
        #1;
        checks++; if (ready[0] !== 1'b1 || im_wr[0] !== 1'b1 || im_addr[0] !== 8'h05 || im_wdata[0] !== 16'h1234) begin
            errors++; $display("FAIL load_wr_mux got=%b%b %h %h exp=11 05 1234", ready[0], im_wr[0], im_addr[0], im_wdata[0]); end
        step();
        host_addr = 8'hFF; host_wdata = 16'hBEEF;
        step();
        host_we = 1'b0; host_addr = 8'h05;
        #1;
        checks++; if (im_rd[0] !== 1'b1 || im_wr[0] !== 1'b0) begin errors++; $display("FAIL load_rd_mux got=%b%b exp=10", im_rd[0], im_wr[0]); end
        step();
        host_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (rvalid[k] !== 1'b1 || rdata[k] !== 16'h1234) begin errors++; $display("FAIL load_readback k=%0d got=%b/%h exp=1/1234", k, rvalid[k], rdata[k]); end
        end
        step();
        checks++; if (rvalid[0] !== 1'b0 || rdata[0] !== 16'h1234) begin errors++; $display("FAIL load_rd_hold got=%b/%h exp=0/1234", rvalid[0], rdata[0]); end
        checks++; if (wr_cnt[0] - wc0 !== 2) begin errors++; $display("FAIL load_wr_count got=%0d exp=2", wr_cnt[0] - wc0); end
    endtask

    task automatic test_run();
        fetch_rd = 1'b1; host_go = 1'b1;
        step();
        host_go = 1'b0;
        checks++; if (start[0] !== 1'b1 || prst[0] !== 1'b0 || st[0] !== 2'd1 || busy[0] !== 1'b1 || cnt0 !== 16'd0) begin
            errors++; $display("FAIL run_first got=%b%b st=%0d busy=%b cnt=%0d exp=10 st=1 busy=1 cnt=0", start[0], prst[0], st[0], busy[0], cnt0); end
        for (int i = 1; i <= 10; i++) begin
            fetch_addr = 8'($urandom);
            stop = (i == 10);
            #1;
            checks++; if (im_addr[0] !== fetch_addr || im_rd[0] !== 1'b1 || im_wr[0] !== 1'b0) begin
                errors++; $display("FAIL run_fetch_mux got=%h %b%b exp=%h 10", im_addr[0], im_rd[0], im_wr[0], fetch_addr); end
            step();
            if (i == 1) begin
                checks++; if (start[0] !== 1'b0) begin errors++; $display("FAIL run_start_pulse got=%b exp=0", start[0]); end
            end
        end
        stop = 1'b0;
        checks++; if (st[0] !== 2'd2) begin errors++; $display("FAIL run_to_drain got=%0d exp=2", st[0]); end
        checks++; if (st[1] !== 2'd3) begin errors++; $display("FAIL run_drain0_halt got=%0d exp=3", st[1]); end
        checks++; if (cnt0 !== 16'd10 || cnt1 !== 16'd10 || cnt2 !== 4'd10) begin errors++; $display("FAIL run_cnt got=%0d/%0d/%0d exp=10", cnt0, cnt1, cnt2); end
        host_valid = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 16'hCAFE; fetch_rd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (st[0] !== 2'd2 || ready[0] !== 1'b0 || im_wr[0] !== 1'b0) begin
                errors++; $display("FAIL drain_stall i=%0d got=st%0d %b%b exp=st2 00", i, st[0], ready[0], im_wr[0]); end
            step();
        end
        checks++; if (st[0] !== 2'd3 || done[0] !== 1'b1 || cnt0 !== 16'd10) begin errors++; $display("FAIL halt_state got=st%0d done=%b cnt=%0d exp=st3 1 10", st[0], done[0], cnt0); end
        checks++; if (ready[0] !== 1'b1 || im_wr[0] !== 1'b1) begin errors++; $display("FAIL halt_accept got=%b%b exp=11", ready[0], im_wr[0]); end
        step();
        host_we = 1'b0;
        step();
        host_valid = 1'b0;
        checks++; if (rvalid[0] !== 1'b1 || rdata[0] !== 16'hCAFE) begin errors++; $display("FAIL halt_readback got=%b/%h exp=1/cafe", rvalid[0], rdata[0]); end
    endtask

    task automatic test_collisions();
        host_go = 1'b1; step(); host_go = 1'b0;
        stop = 1'b1; host_abort = 1'b1; step(); stop = 1'b0; host_abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (st[k] !== 2'd3) begin errors++; $display("FAIL abort_stop k=%0d got=%0d exp=3", k, st[k]); end
        end
        host_go = 1'b1; step(); host_go = 1'b0;
        stop = 1'b1; step(); stop = 1'b0;
        host_go = 1'b1; step(); host_go = 1'b0;
        checks++; if (st[0] !== 2'd2 || start[0] !== 1'b0) begin errors++; $display("FAIL go_in_drain got=st%0d start=%b exp=st2 0", st[0], start[0]); end
        host_abort = 1'b1; step(); host_abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (st[k] !== 2'd3) begin errors++; $display("FAIL abort_any k=%0d got=%0d exp=3", k, st[k]); end
        end
    endtask

    task automatic test_saturation();
        host_go = 1'b1; step(); host_go = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            stop = (i == 20);
            step();
        end
        stop = 1'b0;
        checks++; if (cnt2 !== 4'd15) begin errors++; $display("FAIL sat_cnt4 got=%0d exp=15", cnt2); end
        checks++; if (cnt0 !== 16'd20) begin errors++; $display("FAIL sat_cnt16 got=%0d exp=20", cnt0); end
        host_abort = 1'b1; step(); host_abort = 1'b0;
        host_go = 1'b1; step(); host_go = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (cnt_of(k) !== 0 || start[k] !== 1'b1) begin errors++; $display("FAIL sat_clear k=%0d got=%0d/%b exp=0/1", k, cnt_of(k), start[k]); end
        end
        host_abort = 1'b1; step(); host_abort = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        host_go = 1'b1; step(); host_go = 1'b0;
        step(); step();
        checks++; if (cnt0 !== 16'd2 || st[0] !== 2'd1) begin errors++; $display("FAIL midrun_pre got=cnt%0d st%0d exp=cnt2 st1", cnt0, st[0]); end
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (st[k] !== 2'd0 || prst[k] !== 1'b1 || start[k] !== 1'b0 || cnt_of(k) !== 0) begin
                errors++; $display("FAIL midrun_reset k=%0d got=st%0d %b%b cnt%0d exp=st0 10 cnt0", k, st[k], prst[k], start[k], cnt_of(k)); end
        end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            host_go    = ($urandom_range(0, 7) == 0);
            host_abort = ($urandom_range(0, 15) == 0);
            stop       = ($urandom_range(0, 5) == 0);
            host_valid = 1'($urandom);
            host_we    = 1'($urandom);
            host_addr  = 8'($urandom);
            host_wdata = 16'($urandom);
            fetch_addr = 8'($urandom);
            fetch_rd   = 1'($urandom);
            #1;
            for (int k = 0; k < 3; k++) begin
                bit          hs;
                logic [7:0]  ea;
                hs = (m_state[k] == 0) || (m_state[k] == 3);
                ea = hs ? host_addr : fetch_addr;
                checks++; if (im_addr[k] !== ea) begin errors++; $display("FAIL rnd_im_addr k=%0d got=%h exp=%h", k, im_addr[k], ea); end
                checks++; if (im_rd[k] !== (hs ? (host_valid & ~host_we) : fetch_rd)) begin errors++; $display("FAIL rnd_im_rd k=%0d got=%b", k, im_rd[k]); end
                checks++; if (im_wr[k] !== (hs & host_valid & host_we)) begin errors++; $display("FAIL rnd_im_wr k=%0d got=%b", k, im_wr[k]); end
                if (hs) begin
                    checks++; if (im_wdata[k] !== host_wdata) begin errors++; $display("FAIL rnd_im_wdata k=%0d got=%h exp=%h", k, im_wdata[k], host_wdata); end
                end
            end
            step();
            for (int k = 0; k < 3; k++) begin
                bit hs;
                hs = (m_state[k] == 0) || (m_state[k] == 3);
                checks++; if (int'(st[k]) !== m_state[k]) begin errors++; $display("FAIL rnd_state k=%0d got=%0d exp=%0d", k, st[k], m_state[k]); end
                checks++; if (int'(start[k]) !== m_start[k]) begin errors++; $display("FAIL rnd_start k=%0d got=%b exp=%0d", k, start[k], m_start[k]); end
                checks++; if (prst[k] !== hs || ready[k] !== hs || busy[k] !== !hs || done[k] !== (m_state[k] == 3)) begin
                    errors++; $display("FAIL rnd_flags k=%0d got=%b%b%b%b", k, prst[k], ready[k], busy[k], done[k]); end
                checks++; if (int'(rvalid[k]) !== m_rvalid[k] || rdata[k] !== m_rdata[k]) begin
                    errors++; $display("FAIL rnd_read k=%0d got=%b/%h exp=%0d/%h", k, rvalid[k], rdata[k], m_rvalid[k], m_rdata[k]); end
                checks++; if (cnt_of(k) !== m_cnt[k]) begin errors++; $display("FAIL rnd_cnt k=%0d got=%0d exp=%0d", k, cnt_of(k), m_cnt[k]); end
            end
        end
        host_valid = 1'b0; host_go = 1'b0; host_abort = 1'b0; stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_run();
        test_collisions();
        test_saturation();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
